// File: rtl/sr_reg_dump_uart_pkg.sv
// Shared constants for the register-dump UART: frame layout and FSM encodings.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package sr_reg_dump_uart_pkg;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;
    localparam int         FRAME_WORDS       = 32;
    localparam int         FRAME_BYTES       = 1 + 4 * FRAME_WORDS;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_SYNC = 3'd1;
    localparam logic [2:0] ST_SET  = 3'd2;
    localparam logic [2:0] ST_CAPT = 3'd3;
    localparam logic [2:0] ST_SEND = 3'd4;
    localparam logic [2:0] ST_FIN  = 3'd5;

    // Little-endian byte select: idx 0 is the first byte on the wire.
    function automatic logic [7:0] wordByte(input logic [31:0] word, input logic [1:0] idx);
        case (idx)
            2'd0:    return word[7:0];
            2'd1:    return word[15:8];
            2'd2:    return word[23:16];
            default: return word[31:24];
        endcase
    endfunction

endpackage

// File: rtl/sr_reg_dump_uart_tx.sv
// UART 8N1 byte transmitter, LSB first, each bit held BAUD_DIV cycles.
// Latency: start bit appears on tx the cycle after valid&&ready.
// Backpressure: ready high when idle and in the last stop-bit cycle (gapless bytes).
// Ports: clk, rst (sync, active-high), data/valid/ready byte handshake, tx serial out.
module sr_uart_tx #(
    parameter int BAUD_DIV = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data,
    input  logic       valid,
    output logic       ready,
    output logic       tx
);

    localparam int             CW        = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CW-1:0]  BAUD_LAST = CW'(BAUD_DIV - 1);

    logic          active;
    logic [CW-1:0] baudCnt;
    logic [3:0]    bitIdx;     // 0 = start, 1..8 = data, 9 = stop
    logic [8:0]    shiftReg;   // remaining data bits with the stop bit behind them
    logic          bitEnd;

    assign bitEnd = (baudCnt == BAUD_LAST);
    assign ready  = !active || (bitEnd && (bitIdx == 4'd9));

    always_ff @(posedge clk) begin
        if (rst) begin
            active   <= 1'b0;
            baudCnt  <= '0;
            bitIdx   <= 4'd0;
            shiftReg <= 9'h1FF;
            tx       <= 1'b1;
        end else if (valid && ready) begin
            active   <= 1'b1;
            baudCnt  <= '0;
            bitIdx   <= 4'd0;
            shiftReg <= {1'b1, data};
            tx       <= 1'b0;
        end else if (active) begin
            if (bitEnd) begin
                baudCnt <= '0;
                if (bitIdx == 4'd9) begin
                    active <= 1'b0;
                    tx     <= 1'b1;
                end else begin
                    bitIdx   <= bitIdx + 4'd1;
                    tx       <= shiftReg[0];
                    shiftReg <= {1'b1, shiftReg[8:1]};
                end
            end else begin
                baudCnt <= baudCnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/sr_reg_dump_uart.sv
// Walks debug regAddr 0..31, captures regData and streams SYNC + 32 LE words over UART.
// Latency: start at edge N -> busy from N+1, first start bit from N+2; done after last stop.
// Backpressure: start ignored while busy; bytes handed to the transmitter on its ready.
// Ports: clk, rst (sync), start, regAddr/regData debug port, uartTx, busy, done.
module sr_reg_dump_uart
    import sr_reg_dump_uart_pkg::*;
#(
    parameter int         BAUD_DIV  = 434,
    parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [4:0]  regAddr,
    input  logic [31:0] regData,
    output logic        uartTx,
    output logic        busy,
    output logic        done
);

    localparam logic [4:0] LAST_WORD = 5'(FRAME_WORDS - 1);

    logic [2:0]  state;
    logic [4:0]  wordCnt;
    logic [1:0]  byteCnt;
    logic [31:0] wordReg;
    logic [7:0]  txData;
    logic        txValid;
    logic        txReady;

    always_comb begin
        txValid = 1'b0;
        txData  = SYNC_BYTE;
        case (state)
            ST_SYNC: txValid = 1'b1;
            ST_SEND: begin
                txValid = 1'b1;
                txData  = wordByte(wordReg, byteCnt);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            wordCnt <= 5'd0;
            byteCnt <= 2'd0;
            wordReg <= 32'd0;
            regAddr <= 5'd0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        busy  <= 1'b1;
                        state <= ST_SYNC;
                    end
                end
                ST_SYNC: begin
                    if (txReady) state <= ST_SET;
                end
                ST_SET: begin
                    regAddr <= wordCnt;
                    state   <= ST_CAPT;
                end
                ST_CAPT: begin
                    // Registered capture keeps regData off the serial output path.
                    wordReg <= regData;
                    byteCnt <= 2'd0;
                    state   <= ST_SEND;
                end
                ST_SEND: begin
                    if (txReady) begin
                        byteCnt <= byteCnt + 2'd1;
                        if (byteCnt == 2'd3) begin
                            if (wordCnt == LAST_WORD) begin
                                state <= ST_FIN;
                            end else begin
                                wordCnt <= wordCnt + 5'd1;
                                state   <= ST_SET;
                            end
                        end
                    end
                end
                ST_FIN: begin
                    // Transmitter first raises ready in the final stop-bit cycle of
                    // the last byte, so done lands on the first cycle after it.
                    if (txReady) begin
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        regAddr <= 5'd0;
                        wordCnt <= 5'd0;
                        state   <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    sr_uart_tx #(
        .BAUD_DIV(BAUD_DIV)
    ) uTx (
        .clk  (clk),
        .rst  (rst),
        .data (txData),
        .valid(txValid),
        .ready(txReady),
        .tx   (uartTx)
    );

endmodule
